// File: rtl/mips32_mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// mips32_mem_arbiter_if
//   Bundles the fetch port, data port, halt/err sideband and the memory-array
//   port of the instruction/data memory arbiter.
//   master : the pipeline / environment side (drives requests and mem_rdata)
//   slave  : the arbiter (drives grants, read returns and mem_* controls)
// ---------------------------------------------------------------------------
interface mips32_mem_arbiter_if #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 32
);
   // fetch port
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_gnt;
   logic              if_rvalid;
   logic [DATA_W-1:0] if_rdata;
   // data port
   logic              d_req;
   logic              d_we;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic              d_gnt;
   logic              d_rvalid;
   logic [DATA_W-1:0] d_rdata;
   // sideband
   logic              halt;
   logic              err;
   // memory array port
   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   modport master (
      output if_req, if_addr, d_req, d_we, d_addr, d_wdata, halt, mem_rdata,
      input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata, err,
             mem_en, mem_we, mem_addr, mem_wdata
   );

   modport slave (
      input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, halt, mem_rdata,
      output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata, err,
             mem_en, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/mips32_mem_arbiter.sv
// ---------------------------------------------------------------------------
// mips32_mem_arbiter
//   Shares one single-ported synchronous memory between the instruction-fetch
//   port (read-only) and the MEM-stage data port (load/store). At most one
//   access is granted per cycle; the data port wins unless fetch has already
//   waited STARVE_MAX consecutive data grants. Read data returns one cycle
//   after the grant, steered to the requester that was granted.
// Ports
//   clk  : rising-edge clock
//   rst  : synchronous reset, active high
//   bus  : slave side of mips32_mem_arbiter_if (fetch port, data port,
//          halt/err sideband, memory array port)
// ---------------------------------------------------------------------------
module mips32_mem_arbiter #(
   parameter int ADDR_W     = 10,
   parameter int DATA_W     = 32,
   parameter int MEM_DEPTH  = 1024,
   parameter int STARVE_MAX = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   mips32_mem_arbiter_if.slave  bus
);

   localparam logic [ADDR_W:0] DEPTH_L   = (ADDR_W+1)'(MEM_DEPTH);
   localparam logic [3:0]      STARVE_L  = 4'(STARVE_MAX);

   // registered state
   logic [3:0]        starve_cnt_q, starve_cnt_d;
   logic              if_pend_q,    if_pend_d;     // fetch read in flight
   logic              d_pend_q,     d_pend_d;      // load read in flight
   logic              oor_q,        oor_d;         // last grant was out of range
   logic [DATA_W-1:0] if_rdata_q,   if_rdata_d;    // held fetch data
   logic [DATA_W-1:0] d_rdata_q,    d_rdata_d;     // held load data

   // combinational
   logic              fetch_ok;
   logic              starve_hit;
   logic              if_gnt, d_gnt;
   logic              if_in, d_in, sel_in;
   logic [DATA_W-1:0] rd_val;

   // ---------------- grant and memory drive ----------------
   always_comb begin
      fetch_ok   = bus.if_req & ~bus.halt;
      // fetch has waited long enough: data must yield this cycle
      starve_hit = fetch_ok & (starve_cnt_q == STARVE_L);
      d_gnt      = ~rst & bus.d_req & ~starve_hit;
      if_gnt     = ~rst & ~d_gnt & fetch_ok;

      if_in  = {1'b0, bus.if_addr} < DEPTH_L;
      d_in   = {1'b0, bus.d_addr}  < DEPTH_L;
      sel_in = d_gnt ? d_in : if_in;

      bus.if_gnt    = if_gnt;
      bus.d_gnt     = d_gnt;
      bus.mem_en    = (if_gnt | d_gnt) & sel_in;
      bus.mem_we    = d_gnt & bus.d_we & d_in;
      bus.mem_addr  = '0;
      bus.mem_wdata = '0;
      if (d_gnt) begin
         bus.mem_addr = bus.d_addr;
         if (bus.d_we) bus.mem_wdata = bus.d_wdata;
      end else if (if_gnt) begin
         bus.mem_addr = bus.if_addr;
      end
   end

   // ---------------- next state ----------------
   always_comb begin
      starve_cnt_d = starve_cnt_q;
      if (if_gnt | ~fetch_ok)
         starve_cnt_d = '0;
      else if (d_gnt && starve_cnt_q != STARVE_L)
         starve_cnt_d = starve_cnt_q + 4'd1;

      if_pend_d = if_gnt;
      d_pend_d  = d_gnt & ~bus.d_we;
      // out-of-range flag drives err for loads, fetches and stores alike
      oor_d     = (if_gnt | d_gnt) & ~sel_in;
   end

   // ---------------- read return ----------------
   // An out-of-range read never enabled the memory, so its data is forced to 0.
   // rvalid/err are masked during rst so a read granted just before reset
   // never completes.
   always_comb begin
      rd_val        = oor_q ? '0 : bus.mem_rdata;
      bus.if_rvalid = if_pend_q & ~rst;
      bus.d_rvalid  = d_pend_q & ~rst;
      bus.err       = oor_q & ~rst;

      if_rdata_d = bus.if_rvalid ? rd_val : if_rdata_q;
      d_rdata_d  = bus.d_rvalid  ? rd_val : d_rdata_q;

      bus.if_rdata = rst ? '0 : if_rdata_d;
      bus.d_rdata  = rst ? '0 : d_rdata_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         starve_cnt_q <= '0;
         if_pend_q    <= 1'b0;
         d_pend_q     <= 1'b0;
         oor_q        <= 1'b0;
         if_rdata_q   <= '0;
         d_rdata_q    <= '0;
      end else begin
         starve_cnt_q <= starve_cnt_d;
         if_pend_q    <= if_pend_d;
         d_pend_q     <= d_pend_d;
         oor_q        <= oor_d;
         if_rdata_q   <= if_rdata_d;
         d_rdata_q    <= d_rdata_d;
      end
   end

endmodule
